exc_sequencer: RTL and testbench

- Sequences precise exception entry and ERET return for the 3-stage MIPS core.
- Prioritises the exception causes flagged in the execute stage and kills the faulting instruction's writes.
- Records EPC, cause, BD and BadVAddr, holds the pipeline in a flush window, then issues a single redirect to the handler or to EPC.
- Sits beside the write-suppression logic and drives the PC-select redirect path.

---
 rtl/exc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_exc_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Precise exception entry / ERET return sequencer for the 3-stage MIPS core.
// Prioritises execute-stage causes, latches CP0 state, flushes, then issues one redirect.
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_ex,
    input  logic [31:0] bad_addr,
    input  logic        in_delay,
    input  logic        pc_error,
    input  logic        not_exist,
    input  logic        branch_error,
    input  logic        edr,
    input  logic        edr_store,
    input  logic        ext_int,
    input  logic        eret,
    input  logic        ie_wr,
    input  logic        ie_wdata,
    output logic        kill,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [4:0]  cause_code,
    output logic        bd,
    output logic [31:0] badvaddr,
    output logic        exl,
    output logic        ie,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_target;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_redirect_pc;
    logic [4:0]  r_cause;
    logic        r_bd;
    logic        r_exl;
    logic        r_ie;
    logic        r_redirect;

    logic        w_idle;
    logic        w_c_pc;
    logic        w_c_ri;
    logic        w_c_eret;
    logic        w_c_br;
    logic        w_c_edr;
    logic        w_c_int;
    logic        w_sync;
    logic        w_cause_any;
    logic        w_take_exc;
    logic        w_take_eret;
    logic [4:0]  w_code;
    logic        w_upd_bva;
    logic [31:0] w_bva;

    assign w_idle      = (r_state == S_IDLE);
    assign w_c_pc      = pc_error;
    assign w_c_ri      = ~not_exist;
    assign w_c_eret    = eret & ~r_exl;
    assign w_c_br      = branch_error;
    assign w_c_edr     = edr;
    assign w_c_int     = ext_int & r_ie & ~r_exl;
    // Causes that also veto a legal ERET in the same cycle.
    assign w_sync      = w_c_pc | w_c_ri | w_c_br | w_c_edr;
    assign w_cause_any = w_sync | w_c_eret | w_c_int;
    assign w_take_exc  = w_idle & w_cause_any;
    assign w_take_eret = w_idle & eret & r_exl & ~w_sync;

    assign kill        = ~w_idle | w_cause_any;
    assign busy        = ~w_idle;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign epc         = r_epc;
    assign cause_code  = r_cause;
    assign bd          = r_bd;
    assign badvaddr    = r_badvaddr;
    assign exl         = r_exl;
    assign ie          = r_ie;

    always_comb begin
        w_code    = 5'd0;
        w_upd_bva = 1'b0;
        w_bva     = pc_ex;
        if (w_c_pc) begin
            w_code    = 5'd4;
            w_upd_bva = 1'b1;
            w_bva     = pc_ex;
        end else if (w_c_ri) begin
            w_code = 5'd10;
        end else if (w_c_eret) begin
            w_code = 5'd10;
        end else if (w_c_br) begin
            w_code = 5'd13;
        end else if (w_c_edr) begin
            w_code    = edr_store ? 5'd5 : 5'd4;
            w_upd_bva = 1'b1;
            w_bva     = bad_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_take_exc || w_take_eret) w_state_nxt = S_FLUSH;
            S_FLUSH:    if (r_cnt == 4'd0) w_state_nxt = S_REDIRECT;
            S_REDIRECT: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt         <= 4'd0;
            r_target      <= 32'd0;
            r_epc         <= 32'd0;
            r_badvaddr    <= 32'd0;
            r_redirect_pc <= 32'd0;
            r_cause       <= 5'd0;
            r_bd          <= 1'b0;
            r_exl         <= 1'b0;
            r_ie          <= 1'b0;
            r_redirect    <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take_exc) begin
                        r_cause <= w_code;
                        if (w_upd_bva) r_badvaddr <= w_bva;
                        // Nested entry keeps the original return point.
                        if (!r_exl) begin
                            r_epc <= in_delay ? (pc_ex - 32'd4) : pc_ex;
                            r_bd  <= in_delay;
                        end
                        r_exl    <= 1'b1;
                        r_target <= HANDLER_ADDR;
                        r_cnt    <= CNT_INIT;
                    end else if (w_take_eret) begin
                        r_exl    <= 1'b0;
                        r_target <= r_epc;
                        r_cnt    <= CNT_INIT;
                    end
                    if (!kill && ie_wr) r_ie <= ie_wdata;
                end
                S_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= r_target;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: directed scenarios then random traffic against a
// cycle-count reference model of the exception/ERET sequence.
module tb_exc_sequencer;

    localparam logic [31:0] HANDLER = 32'h0000_0080;
    localparam int          FLUSH   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_ex, bad_addr;
    logic        in_delay, pc_error, not_exist, branch_error, edr, edr_store;
    logic        ext_int, eret, ie_wr, ie_wdata;
    logic        kill, redirect, bd, exl, ie, busy;
    logic [31:0] redirect_pc, epc, badvaddr;
    logic [4:0]  cause_code;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: m_left counts the remaining cycles of the busy window.
    int          m_left;
    logic [31:0] m_epc, m_bva, m_target, m_rpc;
    logic [4:0]  m_cause;
    logic        m_bd, m_exl, m_ie;

    exc_sequencer #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .reset(reset), .pc_ex(pc_ex), .bad_addr(bad_addr),
        .in_delay(in_delay), .pc_error(pc_error), .not_exist(not_exist),
        .branch_error(branch_error), .edr(edr), .edr_store(edr_store),
        .ext_int(ext_int), .eret(eret), .ie_wr(ie_wr), .ie_wdata(ie_wdata),
        .kill(kill), .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc),
        .cause_code(cause_code), .bd(bd), .badvaddr(badvaddr), .exl(exl),
        .ie(ie), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_in();
        pc_ex = 32'h0; bad_addr = 32'h0; in_delay = 0; pc_error = 0; not_exist = 1;
        branch_error = 0; edr = 0; edr_store = 0; ext_int = 0; eret = 0;
        ie_wr = 0; ie_wdata = 0;
    endtask

    function automatic logic any_cause();
        return pc_error || !not_exist || (eret && !m_exl) || branch_error || edr ||
               (ext_int && m_ie && !m_exl);
    endfunction

    // Observe the current cycle, then advance the model across the posedge.
    task automatic cycle();
        logic [4:0]  code;
        logic        sync;
        #1;
        chk("kill", 32'(kill), 32'((m_left > 0) || any_cause()));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("redirect", 32'(redirect), 32'(m_left == 1));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("epc", epc, m_epc);
        chk("cause_code", 32'(cause_code), 32'(m_cause));
        chk("bd", 32'(bd), 32'(m_bd));
        chk("badvaddr", badvaddr, m_bva);
        chk("exl", 32'(exl), 32'(m_exl));
        chk("ie", 32'(ie), 32'(m_ie));
        @(posedge clk);
        if (!reset) begin
            m_left = 0; m_epc = 0; m_bva = 0; m_target = 0; m_rpc = 0;
            m_cause = 0; m_bd = 0; m_exl = 0; m_ie = 0;
        end else if (m_left > 0) begin
            if (m_left == 2) m_rpc = m_target;
            m_left--;
        end else begin
            sync = pc_error || !not_exist || branch_error || edr;
            if (any_cause()) begin
                if (pc_error)              begin code = 4;  m_bva = pc_ex; end
                else if (!not_exist)       code = 10;
                else if (eret && !m_exl)   code = 10;
                else if (branch_error)     code = 13;
                else if (edr)              begin code = edr_store ? 5 : 4; m_bva = bad_addr; end
                else                       code = 0;
                m_cause = code;
                if (!m_exl) begin
                    m_epc = in_delay ? pc_ex - 32'd4 : pc_ex;
                    m_bd  = in_delay;
                end
                m_exl = 1; m_target = HANDLER; m_left = FLUSH + 1;
            end else begin
                if (eret && m_exl && !sync) begin
                    m_exl = 0; m_target = m_epc; m_left = FLUSH + 1;
                end
                if (ie_wr) m_ie = ie_wdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        idle_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        m_left = 0; m_epc = 'x; m_bva = 'x; m_rpc = 'x; m_target = 'x;
        m_cause = 'x; m_bd = 'x; m_exl = 'x; m_ie = 'x;
        idle_in();
        reset = 0;
        @(negedge clk);
        @(posedge clk);
        m_epc = 0; m_bva = 0; m_target = 0; m_rpc = 0;
        m_cause = 0; m_bd = 0; m_exl = 0; m_ie = 0;
        @(negedge clk);
        cycle();
        reset = 1;

        // Reserved instruction from a clean state.
        pc_ex = 32'h100; not_exist = 0;
        cycle();
        run_idle(2);
        chk("t1_redirect", 32'(redirect), 32'd1);
        chk("t1_redirect_pc", redirect_pc, 32'h80);
        chk("t1_epc", epc, 32'h100);
        chk("t1_cause", 32'(cause_code), 32'd10);
        chk("t1_exl_bd", {exl, bd}, 2'b10);
        run_idle(1);
        eret = 1; cycle(); run_idle(3);

        // Store address error in a delay slot.
        pc_ex = 32'h204; in_delay = 1; edr = 1; edr_store = 1; bad_addr = 32'h1003;
        cycle(); run_idle(3);
        chk("t2_epc", epc, 32'h200);
        chk("t2_bd", 32'(bd), 32'd1);
        chk("t2_cause", 32'(cause_code), 32'd5);
        chk("t2_bva", badvaddr, 32'h1003);
        eret = 1; cycle(); run_idle(3);

        // Fetch misalignment outranks a data error.
        pc_ex = 32'h402; pc_error = 1; edr = 1; bad_addr = 32'h777;
        cycle(); run_idle(3);
        chk("t3_cause", 32'(cause_code), 32'd4);
        chk("t3_bva", badvaddr, 32'h402);
        eret = 1; cycle(); run_idle(3);

        // Interrupt entry, masked interrupt under exl, then ERET back to epc.
        ie_wr = 1; ie_wdata = 1; cycle(); idle_in();
        chk("t4_ie", 32'(ie), 32'd1);
        pc_ex = 32'h500; ext_int = 1; cycle(); run_idle(3);
        chk("t4_cause", 32'(cause_code), 32'd0);
        chk("t4_exl", 32'(exl), 32'd1);
        ext_int = 1; #1;
        chk("t4_masked_kill", 32'(kill), 32'd0);
        cycle();
        idle_in(); eret = 1; cycle(); run_idle(2);
        chk("t4_eret_redirect", 32'(redirect), 32'd1);
        chk("t4_eret_pc", redirect_pc, 32'h500);
        chk("t4_eret_exl", 32'(exl), 32'd0);
        run_idle(1);

        // Nested branch error keeps epc; bad ERET with exl==0 traps.
        pc_ex = 32'h100; not_exist = 0; cycle(); run_idle(3);
        pc_ex = 32'h300; branch_error = 1; cycle(); run_idle(3);
        chk("t5_cause", 32'(cause_code), 32'd13);
        chk("t5_epc", epc, 32'h100);
        eret = 1; cycle(); run_idle(3);
        eret = 1; pc_ex = 32'h600; #1;
        chk("t5_bad_eret_kill", 32'(kill), 32'd1);
        cycle(); run_idle(3);
        chk("t5_bad_eret_cause", 32'(cause_code), 32'd10);
        chk("t5_bad_eret_exl", 32'(exl), 32'd1);

        // Sync exception beats ERET in the same cycle.
        eret = 1; branch_error = 1; pc_ex = 32'h700; cycle(); run_idle(3);
        chk("t6_exc_beats_eret_exl", 32'(exl), 32'd1);
        chk("t6_exc_beats_eret_cause", 32'(cause_code), 32'd13);
        eret = 1; cycle(); run_idle(3);

        // epc wraps below address zero.
        pc_ex = 32'h0; in_delay = 1; not_exist = 0; cycle(); run_idle(3);
        chk("t7_epc_wrap", epc, 32'hFFFF_FFFC);
        eret = 1; cycle(); run_idle(3);

        // Interrupt wins over a same-cycle IE write.
        ext_int = 1; ie_wr = 1; ie_wdata = 0; cycle(); run_idle(3);
        chk("t8_ie_kept", 32'(ie), 32'd1);
        eret = 1; cycle(); run_idle(3);

        // Reset in the middle of the flush window aborts the redirect.
        not_exist = 0; pc_ex = 32'h900; cycle(); run_idle(1);
        reset = 0; cycle(); reset = 1;
        chk("t9_busy", 32'(busy), 32'd0);
        chk("t9_redirect", 32'(redirect), 32'd0);
        chk("t9_regs", {epc, badvaddr, redirect_pc}, 96'd0);
        chk("t9_flags", {cause_code, bd, exl, ie}, 8'd0);
        run_idle(4);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            idle_in();
            pc_ex        = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) pc_ex = pc_ex | 32'($urandom_range(1, 3));
            bad_addr     = $urandom;
            in_delay     = ($urandom_range(0, 3) == 0);
            pc_error     = ($urandom_range(0, 19) == 0);
            not_exist    = ($urandom_range(0, 19) != 0);
            branch_error = ($urandom_range(0, 19) == 0);
            edr          = ($urandom_range(0, 14) == 0);
            edr_store    = $urandom_range(0, 1);
            ext_int      = ($urandom_range(0, 5) == 0);
            eret         = ($urandom_range(0, 7) == 0);
            ie_wr        = ($urandom_range(0, 5) == 0);
            ie_wdata     = $urandom_range(0, 1);
            reset        = ($urandom_range(0, 79) != 0);
            cycle();
            reset = 1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
